// File: rtl/regfile_multiport.sv
// Multiport register file: NUM_RD sync read ports, one write port, debug port.
// Built-in reset-image loader; `REGFILE_BYPASS_EN enables write-first read ports.
module regfile_multiport #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 5,
  parameter int                 DEPTH    = 1 << ADDR_W,
  parameter int                 NUM_RD   = 2,
  parameter int                 SP_INDEX = 29,
  parameter logic [DATA_W-1:0]  SP_INIT  = 32'h000000FC
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic [ADDR_W-1:0]        write_address,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [NUM_RD*ADDR_W-1:0] read_address,
  output logic [NUM_RD*DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0]        read_address_debug,
  output logic [DATA_W-1:0]        data_out_debug,
  output logic                     init_busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              ptr_q, ptr_d;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0]              dbg_q, dbg_d;
  logic [DATA_W-1:0]              mem_q [DEPTH];

  logic                           mem_we;
  logic [IDX_W-1:0]               mem_wa;
  logic [DATA_W-1:0]              mem_wd;
  logic                           wr_ok;
  logic [ADDR_W-1:0]              rd_addr [NUM_RD];

  // Unpack the flat read address bus into per-port indices
  for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
    assign rd_addr[k] = read_address[k*ADDR_W +: ADDR_W];
  end

  // A run-time write lands only for a nonzero, in-range address
  assign wr_ok = write_en && (write_address != '0) &&
                 (32'(write_address) < DEPTH);

  // Next-state: init loader, write decode and read-port capture
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rd_d    = '0;
    dbg_d   = '0;
    mem_we  = 1'b0;
    mem_wa  = ptr_q[IDX_W-1:0];
    mem_wd  = '0;
    unique case (state_q)
      INIT: begin
        mem_we = 1'b1;
        unique case (1'b1)
          (ptr_q == '0):            mem_wd = '0;
          (32'(ptr_q) == SP_INDEX): mem_wd = SP_INIT;
          default:                  mem_wd = DATA_W'(ptr_q);
        endcase
        ptr_d = ptr_q + 1'b1;
        if (32'(ptr_q) == DEPTH - 1) begin
          state_d = RUN;
          ptr_d   = '0;
        end
      end
      RUN: begin
        mem_we = wr_ok;
        mem_wa = write_address[IDX_W-1:0];
        mem_wd = data_in;
        for (int k = 0; k < NUM_RD; k++) begin
          if (rd_addr[k] != '0 && 32'(rd_addr[k]) < DEPTH)
            rd_d[k] = mem_q[rd_addr[k][IDX_W-1:0]];
`ifdef REGFILE_BYPASS_EN
          if (wr_ok && rd_addr[k] == write_address)
            rd_d[k] = data_in;
`endif
        end
        if (32'(read_address_debug) < DEPTH)
          dbg_d = mem_q[read_address_debug[IDX_W-1:0]];
      end
      default: state_d = INIT;
    endcase
  end

  // Control state and registered read outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
      rd_q    <= '0;
      dbg_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
      dbg_q   <= dbg_d;
    end
  end

  // Storage array; frozen while reset is asserted
  always_ff @(posedge clock) begin
    if (reset && mem_we)
      mem_q[mem_wa] <= mem_wd;
  end

  assign data_out       = rd_q;
  assign data_out_debug = dbg_q;
  assign init_busy      = (state_q == INIT);

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport (default parameters).
// Define REGFILE_BYPASS_EN for both RTL and bench to test write-first reads.
module tb_regfile_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int S_DBG  = 4;
  localparam int S_BUSY = 5;

  logic           clock = 1'b0;
  logic           reset;
  logic           write_en;
  logic [AW-1:0]  write_address;
  logic [DW-1:0]  data_in;
  logic [NR*AW-1:0] read_address;
  logic [NR*DW-1:0] data_out;
  logic [AW-1:0]  read_address_debug;
  logic [DW-1:0]  data_out_debug;
  logic           init_busy;

  regfile_multiport dut (
    .clock              (clock),
    .reset              (reset),
    .write_en           (write_en),
    .write_address      (write_address),
    .data_in            (data_in),
    .read_address       (read_address),
    .data_out           (data_out),
    .read_address_debug (read_address_debug),
    .data_out_debug     (data_out_debug),
    .init_busy          (init_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Expectation for the state right after the coming posedge
  task automatic expect_v(input int sel, input logic [31:0] v,
                          input string nm);
    exp_t e;
    e.cyc = cyc + 1;
    e.sel = sel;
    e.exp = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] r0,
                       input logic [4:0] r1, input logic [4:0] rdbg);
    write_en           = we;
    write_address      = wa;
    data_in            = wd;
    read_address       = {r1, r0};
    read_address_debug = rdbg;
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  // Monitor: compare every expectation due on this edge
  always @(posedge clock) begin
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      unique case (1'b1)
        (e.sel < NR):      act = data_out[e.sel*DW +: DW];
        (e.sel == S_DBG):  act = data_out_debug;
        default:           act = {31'b0, init_busy};
      endcase
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s: expectation missed its cycle", e.nm);
      end else if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [31:0] byp9;
  logic [31:0] byp5_0;

  initial begin
`ifdef REGFILE_BYPASS_EN
    byp9   = 32'h12345678;
`else
    byp9   = 32'd9;
`endif
    byp5_0 = 32'd1;
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd29, 5'd3);
    tick();
    expect_v(0, 32'd0, "rst_p0");
    expect_v(1, 32'd0, "rst_p1");
    expect_v(S_DBG, 32'd0, "rst_dbg");
    expect_v(S_BUSY, 32'd1, "rst_busy");
    tick();
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (i == 5)
        drive(1'b1, 5'd3, 32'hAAAA5555, 5'd7, 5'd29, 5'd3);
      else
        drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd29, 5'd3);
      expect_v(S_BUSY, (i < 32) ? 32'd1 : 32'd0, "init_busy");
      if (i == 5 || i == 32) begin
        expect_v(0, 32'd0, "init_p0_zero");
        expect_v(S_DBG, 32'd0, "init_dbg_zero");
      end
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd29, 5'd0);
    expect_v(0, 32'd7, "img_a7");
    expect_v(1, 32'h000000FC, "img_sp");
    expect_v(S_DBG, 32'd0, "img_dbg0");
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 5'd3);
    expect_v(0, 32'd3, "init_wr_ignored");
    expect_v(1, 32'd0, "img_a0");
    expect_v(S_DBG, 32'd3, "dbg_a3");
    tick();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 5'd31);
    expect_v(0, byp5_0, "other_port_a1");
    expect_v(1, 32'd2, "other_port_a2");
    expect_v(S_DBG, 32'd31, "dbg_a31");
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
    expect_v(0, 32'hDEADBEEF, "wr5_p0");
    expect_v(1, 32'hDEADBEEF, "wr5_p1");
    expect_v(S_DBG, 32'hDEADBEEF, "wr5_dbg");
    tick();
    drive(1'b1, 5'd9, 32'h12345678, 5'd9, 5'd9, 5'd9);
    expect_v(0, byp9, "same_edge_p0");
    expect_v(1, byp9, "same_edge_p1");
    expect_v(S_DBG, 32'd9, "same_edge_dbg");
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd8, 5'd9);
    expect_v(0, 32'h12345678, "wr9_p0");
    expect_v(1, 32'd8, "a8_p1");
    expect_v(S_DBG, 32'h12345678, "wr9_dbg");
    tick();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    expect_v(0, 32'd0, "wr0_same_p0");
    expect_v(1, 32'd0, "wr0_same_p1");
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    expect_v(0, 32'd0, "wr0_p0");
    expect_v(1, 32'd0, "wr0_p1");
    expect_v(S_DBG, 32'd0, "wr0_dbg");
    tick();
    drive(1'b1, 5'd31, 32'h31313131, 5'd30, 5'd31, 5'd29);
    expect_v(S_DBG, 32'h000000FC, "dbg_sp");
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd30, 5'd31);
    expect_v(0, 32'h31313131, "wr31_p0");
    expect_v(1, 32'd30, "a30_p1");
    expect_v(S_DBG, 32'h31313131, "wr31_dbg");
    expect_v(S_BUSY, 32'd0, "run_busy");
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
    expect_v(0, 32'd0, "rst2_p0");
    expect_v(S_DBG, 32'd0, "rst2_dbg");
    expect_v(S_BUSY, 32'd1, "rst2_busy");
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      expect_v(S_BUSY, 32'd1, "partial_busy");
      tick();
    end
    reset = 1'b0;
    expect_v(S_BUSY, 32'd1, "midinit_rst_busy");
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      expect_v(S_BUSY, (i < 32) ? 32'd1 : 32'd0, "reinit_busy");
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd9, 5'd31);
    expect_v(0, 32'd5, "reinit_a5");
    expect_v(1, 32'd9, "reinit_a9");
    expect_v(S_DBG, 32'd31, "reinit_a31");
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd12, 5'd0);
    expect_v(0, 32'h000000FC, "reinit_sp");
    expect_v(1, 32'd12, "reinit_a12");
    tick();
    tick();
    tick();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d left expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
